// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into one memory transaction.
// Byte/halfword/word loads are extracted and extended from the memory word,
// stores get lane-replicated data and byte enables. A two-state FSM (IDLE/BUSY)
// stalls the core until the memory signals completion.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    state_t      state_r;
    logic        we_r;
    logic [2:0]  size_r;
    logic [1:0]  addr_lo_r;
    logic [3:0]  be_r;
    logic [31:0] addr_r;
    logic [31:0] wd_r;
    logic        legal_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Access is legal when its size code is defined and the address is naturally aligned.
    function automatic logic is_legal(input logic [2:0] sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = (lo[0] == 1'b0);
            SZ_W:        ok = (lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a store; loads always read the full word.
    function automatic logic [3:0] store_be(input logic [2:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            SZ_B, SZ_BU: be = 4'b0001 << lo;
            SZ_H, SZ_HU: be = lo[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the byte enables pick the right one.
    function automatic logic [31:0] store_data(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            SZ_B, SZ_BU: d = {4{wd[7:0]}};
            SZ_H, SZ_HU: d = {2{wd[15:0]}};
            default:     d = wd;
        endcase
        return d;
    endfunction

    assign legal_s = is_legal(core_size_i, core_addr_i[1:0]);

    // FSM and latched transaction; memory-side outputs are the latched registers,
    // which stay zero in IDLE and are cleared on completion or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            we_r      <= 1'b0;
            size_r    <= 3'd0;
            addr_lo_r <= 2'd0;
            be_r      <= 4'd0;
            addr_r    <= 32'd0;
            wd_r      <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (core_req_i && legal_s) begin
                        state_r   <= BUSY;
                        we_r      <= core_we_i;
                        size_r    <= core_size_i;
                        addr_lo_r <= core_addr_i[1:0];
                        be_r      <= core_we_i ? store_be(core_size_i, core_addr_i[1:0]) : 4'b1111;
                        addr_r    <= {core_addr_i[31:2], 2'b00};
                        wd_r      <= store_data(core_size_i, core_wd_i);
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        state_r   <= IDLE;
                        we_r      <= 1'b0;
                        size_r    <= 3'd0;
                        addr_lo_r <= 2'd0;
                        be_r      <= 4'd0;
                        addr_r    <= 32'd0;
                        wd_r      <= 32'd0;
                    end else begin
                        state_r   <= BUSY;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    we_r      <= 1'b0;
                    size_r    <= 3'd0;
                    addr_lo_r <= 2'd0;
                    be_r      <= 4'd0;
                    addr_r    <= 32'd0;
                    wd_r      <= 32'd0;
                end
            endcase
        end
    end

    assign mem_req_o  = (state_r == BUSY);
    assign mem_we_o   = we_r;
    assign mem_be_o   = be_r;
    assign mem_addr_o = addr_r;
    assign mem_wd_o   = wd_r;

    // Stall/error handshake: IDLE judges the incoming request, BUSY waits for memory.
    always_comb begin
        core_stall_o = 1'b0;
        core_err_o   = 1'b0;
        if (state_r == BUSY) begin
            core_stall_o = ~mem_ready_i;
        end else if (core_req_i) begin
            core_stall_o = legal_s;
            core_err_o   = ~legal_s;
        end else begin
            core_stall_o = 1'b0;
            core_err_o   = 1'b0;
        end
    end

    // Lane selection from the returned word using the latched low address bits.
    always_comb begin
        byte_s = 8'd0;
        case (addr_lo_r)
            2'd0:    byte_s = mem_rd_i[7:0];
            2'd1:    byte_s = mem_rd_i[15:8];
            2'd2:    byte_s = mem_rd_i[23:16];
            2'd3:    byte_s = mem_rd_i[31:24];
            default: byte_s = 8'd0;
        endcase
        if (addr_lo_r[1]) begin
            half_s = mem_rd_i[31:16];
        end else begin
            half_s = mem_rd_i[15:0];
        end
    end

    // Load data extension; zero whenever no load is in flight.
    always_comb begin
        core_rd_o = 32'd0;
        if (state_r == BUSY && !we_r) begin
            case (size_r)
                SZ_B:    core_rd_o = {{24{byte_s[7]}}, byte_s};
                SZ_BU:   core_rd_o = {24'd0, byte_s};
                SZ_H:    core_rd_o = {{16{half_s[15]}}, half_s};
                SZ_HU:   core_rd_o = {16'd0, half_s};
                SZ_W:    core_rd_o = mem_rd_i;
                default: core_rd_o = 32'd0;
            endcase
        end else begin
            core_rd_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// reset/back-to-back sequences, and randomized accesses against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad = 0;

    load_store_unit dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
        .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
        .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_nbytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        if (sz == 3'd2) return 4;
        return 0;
    endfunction

    function automatic logic m_legal(input logic [2:0] sz, input logic [31:0] a);
        int nb;
        nb = m_nbytes(sz);
        if (nb == 0) return 1'b0;
        return ((a % nb) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic w, input logic [2:0] sz, input logic [31:0] a);
        int b;
        if (!w) return 4'hF;
        b = ((1 << m_nbytes(sz)) - 1) << (a % 4);
        return b[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] d);
        longint v;
        case (m_nbytes(sz))
            1:       v = longint'(d % 256) * 64'h0101_0101;
            2:       v = longint'(d % 65536) * 64'h0001_0001;
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_rd(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        longint v;
        int nb;
        int bits;
        if (w) return 32'd0;
        nb = m_nbytes(sz);
        if (nb == 4) return d;
        bits = 8 * nb;
        v = (longint'(d) >> (8 * (a % 4))) % (64'd1 << bits);
        if (sz < 3'd4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // One complete access: request cycle, 'waits' stalled BUSY cycles, completion, idle check.
    task automatic run_txn(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rdv, input int waits,
                           input logic e_err, input logic [3:0] e_be, input logic [31:0] e_addr,
                           input logic [31:0] e_wd, input logic [31:0] e_rd);
        @(negedge clk);
        core_req = 1'b1; core_we = w; core_size = sz; core_addr = a; core_wd = d;
        mem_ready = 1'b0; mem_rd = rdv;
        #1;
        chk("req_err", {31'd0, core_err}, {31'd0, e_err});
        chk("req_stall", {31'd0, core_stall}, {31'd0, ~e_err});
        chk("req_memreq", {31'd0, mem_req}, 32'd0);
        if (!e_err) begin
            for (int i = 0; i <= waits; i++) begin
                @(negedge clk);
                core_req = 1'b0;
                core_addr = $urandom; core_wd = $urandom; core_size = 3'($urandom);
                mem_ready = (i == waits);
                #1;
                chk("busy_memreq", {31'd0, mem_req}, 32'd1);
                chk("busy_we", {31'd0, mem_we}, {31'd0, w});
                chk("busy_be", {28'd0, mem_be}, {28'd0, e_be});
                chk("busy_addr", mem_addr, e_addr);
                if (w) chk("busy_wd", mem_wd, e_wd);
                chk("busy_stall", {31'd0, core_stall}, {31'd0, (i != waits)});
                chk("busy_rd", core_rd, e_rd);
            end
        end
        @(negedge clk);
        core_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("idle_memreq", {31'd0, mem_req}, 32'd0);
        chk("idle_stall", {31'd0, core_stall}, 32'd0);
        chk("idle_be", {28'd0, mem_be}, 32'd0);
        chk("idle_rd", core_rd, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waits;
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 3, 1'b0, 4'hF, 32'h100, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 3, 1'b0, 4'hF, 32'h100, 32'h0, 32'h00000080};
        vecs[3]  = '{1'b1, 3'd1, 32'h22, 32'h1234ABCD, 32'h0, 2, 1'b0, 4'hC, 32'h20, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'h80011234, 1, 1'b0, 4'hF, 32'h100, 32'h0, 32'hFFFF8001};
        vecs[7]  = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h80011234, 1, 1'b0, 4'hF, 32'h100, 32'h0, 32'h00008001};
        vecs[8]  = '{1'b1, 3'd0, 32'h42, 32'hA5, 32'h0, 0, 1'b0, 4'h4, 32'h40, 32'hA5A5A5A5, 32'h0};
        vecs[9]  = '{1'b1, 3'd2, 32'h1004, 32'hCAFEF00D, 32'h0, 1, 1'b0, 4'hF, 32'h1004, 32'hCAFEF00D, 32'h0};
        vecs[10] = '{1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 3'd7, 32'h200, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 3'd0, 32'h100, 32'h0, 32'h0000007F, 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0000007F};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_rd", core_rd, 32'd0);
        chk("rst_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_err", {31'd0, core_err}, 32'd0);

        // mem_ready in IDLE is ignored
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("idle_ready_stall", {31'd0, core_stall}, 32'd0);
        chk("idle_ready_memreq", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("idle_ready_memreq2", {31'd0, mem_req}, 32'd0);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].waits,
                    vecs[i].e_err, vecs[i].e_be, vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_rd);
        end

        // Reset in the middle of an outstanding load
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h300; mem_ready = 1'b0;
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk("abort_busy", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_memreq", {31'd0, mem_req}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_be", {28'd0, mem_be}, 32'd0);
        chk("abort_stall", {31'd0, core_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1; mem_rd = 32'h55AA55AA;
            #1;
            chk("abort_late_memreq", {31'd0, mem_req}, 32'd0);
            chk("abort_late_rd", core_rd, 32'd0);
            chk("abort_late_stall", {31'd0, core_stall}, 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b0;

        // Back-to-back: sb then lhu with core_req held high
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd0; core_addr = 32'h3; core_wd = 32'h11;
        #1;
        chk("b2b_sb_stall", {31'd0, core_stall}, 32'd1);
        @(negedge clk);
        core_we = 1'b0; core_size = 3'd5; core_addr = 32'h6; mem_ready = 1'b1; mem_rd = 32'hBEEF0000;
        #1;
        chk("b2b_sb_memreq", {31'd0, mem_req}, 32'd1);
        chk("b2b_sb_we", {31'd0, mem_we}, 32'd1);
        chk("b2b_sb_be", {28'd0, mem_be}, 32'h8);
        chk("b2b_sb_wd", mem_wd, 32'h11111111);
        chk("b2b_sb_stall0", {31'd0, core_stall}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("b2b_gap_memreq", {31'd0, mem_req}, 32'd0);
        chk("b2b_lhu_stall", {31'd0, core_stall}, 32'd1);
        @(negedge clk);
        core_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk("b2b_lhu_memreq", {31'd0, mem_req}, 32'd1);
        chk("b2b_lhu_we", {31'd0, mem_we}, 32'd0);
        chk("b2b_lhu_addr", mem_addr, 32'h4);
        chk("b2b_lhu_rd", core_rd, 32'h0000BEEF);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("b2b_end_memreq", {31'd0, mem_req}, 32'd0);

        // Randomized accesses against the model
        for (int n = 0; n < 200; n++) begin
            logic        w;
            logic [2:0]  sz;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] r;
            int          wt;
            w  = 1'($urandom);
            sz = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d  = $urandom;
            r  = $urandom;
            wt = $urandom_range(0, 3);
            run_txn(w, sz, a, d, r, wt, ~m_legal(sz, a), m_be(w, sz, a),
                    {a[31:2], 2'b00}, m_wd(sz, d), m_rd(w, sz, a, r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (rising edge only); rst_i input 1 (synchronous, active-high).
REQ-002 The core-side ports SHALL be: core_req_i in 1 (access request); core_we_i in 1 (1=store); core_size_i in 3 (0=B, 1=H, 2=W, 4=BU, 5=HU); core_addr_i in 32 (byte address); core_wd_i in 32 (store data).
REQ-003 The core-side outputs SHALL be: core_rd_o out 32 (extended load data); core_stall_o out 1 (freeze core/PC); core_err_o out 1 (misaligned or illegal size).
REQ-004 The memory-side ports SHALL be: mem_req_o out 1; mem_we_o out 1; mem_be_o out 4 (byte enables); mem_addr_o out 32 (word-aligned); mem_wd_o out 32; mem_rd_i in 32; mem_ready_i in 1 (access complete this cycle).

Function
REQ-005 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-006 An access is legal when: size is B or BU (any offset); size is H or HU and addr[0]=0; size is W and addr[1:0]=0. Size codes 3, 6 and 7 are illegal.
REQ-007 In IDLE with core_req_i=1 and a legal access: core_stall_o=1 (combinational); the block latches we, size, addr and wd; the next state is BUSY.
REQ-008 In IDLE with core_req_i=1 and an illegal access: core_err_o=1 (combinational); core_stall_o=0; no memory transaction; the state stays IDLE.
REQ-009 In IDLE with core_req_i=0: core_stall_o=0; core_err_o=0.
REQ-010 In BUSY: mem_req_o=1; mem_we_o, mem_addr_o, mem_be_o and mem_wd_o SHALL come only from the latched values and stay stable for the whole of BUSY.
REQ-011 In BUSY: core_stall_o = NOT mem_ready_i. A cycle with mem_ready_i=1 is the completion cycle; the next state is IDLE.
REQ-012 mem_ready_i SHALL be ignored in IDLE.
REQ-013 Minimum latency is 2 cycles, request to unstalled cycle (request cycle stalled; completion cycle in BUSY unstalled). Each additional cycle with mem_ready_i=0 adds one stalled cycle.
REQ-014 mem_addr_o = {addr[31:2], 2'b00}.
REQ-015 Store byte enables: B gives 4'b0001 shifted left by addr[1:0]; H gives 4'b0011 when addr[1]=0, else 4'b1100; W gives 4'b1111.
REQ-016 Load byte enables: mem_be_o=4'b1111.
REQ-017 Store data: B gives wd[7:0] replicated 4 times; H gives wd[15:0] replicated 2 times; W gives wd unchanged.
REQ-018 core_rd_o in BUSY takes the byte or halfword of mem_rd_i selected by the latched addr[1:0]:
- B and H: sign-extended to 32 bits.
- BU and HU: zero-extended to 32 bits.
- W: mem_rd_i unchanged.
REQ-019 core_rd_o SHALL be 0 in IDLE and for stores.
REQ-020 A new core_req_i in the completion cycle SHALL NOT start a transaction; requests are sampled only in IDLE.
REQ-021 In IDLE: mem_req_o=0; mem_we_o=0; mem_be_o=0; mem_addr_o=0; mem_wd_o=0.

Reset
REQ-022 rst_i=1 at a clock edge SHALL force IDLE and clear all latched registers, in any state, including BUSY with a transaction outstanding.
REQ-023 In the cycle after reset: mem_req_o=0; mem_we_o=0; mem_be_o=0; mem_addr_o=0; mem_wd_o=0; core_rd_o=0; core_stall_o=0 if core_req_i=0; core_err_o=0 if core_req_i=0.
REQ-024 An aborted transaction SHALL NOT be resumed, and mem_ready_i arriving after reset SHALL be ignored.

Verification
REQ-025 Word load, zero-wait: lw addr 0x100, mem_ready_i=1 in the first BUSY cycle, mem_rd_i=0xDEADBEEF.
- Request cycle: stall=1.
- Next cycle: mem_req_o=1, mem_addr_o=0x100, mem_be_o=4'b1111, stall=0, core_rd_o=0xDEADBEEF.
REQ-026 Byte loads, 3 wait cycles: address 0x103, mem_rd_i=0x80FF0000.
- lb: core_rd_o=0xFFFFFF80.
- lbu: core_rd_o=0x00000080.
- Stall high for 4 consecutive cycles, then low for one cycle.
REQ-027 Halfword store: sh addr 0x22, wd=0x1234ABCD -> mem_we_o=1, mem_addr_o=0x20, mem_be_o=4'b1100, mem_wd_o=0xABCDABCD; latched outputs stable across 2 wait cycles.
REQ-028 Misaligned and illegal requests: lw addr 0x102 -> core_err_o=1, stall=0, mem_req_o stays 0; size code 3 gives the same response.
REQ-029 Reset mid-transaction: rst_i while BUSY with mem_ready_i=0 -> next cycle IDLE, mem_req_o=0; a later mem_ready_i=1 causes no output change.
REQ-030 Back-to-back accesses: sb followed immediately by lhu (core_req_i held high) -> two separate BUSY episodes, the lhu latched only after returning to IDLE; mem_req_o deasserted for at least one cycle between them.
